// File: rtl/mul_seq_ctrl.sv
// mul_seq_ctrl: iterative radix-2 shift-add MUL sequencer for EX.
// Ports: clk_i, rst_i (async, active-low), start_i, ALUCtrl_i,
//   flush_i, data1_i/data2_i (operands) -> stall_o, busy_o,
//   valid_o (one-cycle pulse), result_o (low WIDTH product bits).
// Option: MUL_EARLY_TERM_EN leaves BUSY once the multiplier
//   has no set bits left (same results, shorter latency).
module mul_seq_ctrl #(
  parameter int          WIDTH    = 32,
  parameter logic [2:0]  MUL_CODE = 3'b010
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [2:0]       ALUCtrl_i,
  input  logic             flush_i,
  input  logic [WIDTH-1:0] data1_i,
  input  logic [WIDTH-1:0] data2_i,
  output logic             stall_o,
  output logic             busy_o,
  output logic             valid_o,
  output logic [WIDTH-1:0] result_o
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] res_q, res_d;

  logic             accept;
  logic             step;
  logic             last_step;
  logic [WIDTH-1:0] acc_sum;
  logic [WIDTH-1:0] mplier_sh;

  assign accept = start_i
                & (ALUCtrl_i == MUL_CODE)
                & ~flush_i
                & (state_q != S_BUSY);

  // One shift-add iteration per BUSY cycle unless flushed.
  assign step      = (state_q == S_BUSY) & ~flush_i;
  assign acc_sum   = acc_q + (mplier_q[0] ? mcand_q : '0);
  assign mplier_sh = mplier_q >> 1;

`ifdef MUL_EARLY_TERM_EN
  assign last_step = (cnt_q == LAST) | (mplier_sh == '0);
`else
  assign last_step = (cnt_q == LAST);
`endif

  // State register
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) state_d = S_BUSY;
      end
      S_BUSY: begin
        if (flush_i)        state_d = S_IDLE;
        else if (last_step) state_d = S_DONE;
      end
      S_DONE: begin
        state_d = accept ? S_BUSY : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      res_q    <= '0;
    end else begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      res_q    <= res_d;
    end
  end

  // Datapath next values; the result is captured on the
  // final step so it stays stable after DONE.
  always_comb begin
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    res_d    = res_q;
    if (accept) begin
      acc_d    = '0;
      mcand_d  = data1_i;
      mplier_d = data2_i;
      cnt_d    = '0;
    end else if (step) begin
      acc_d    = acc_sum;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_sh;
      cnt_d    = cnt_q + CW'(1);
      if (last_step) res_d = acc_sum;
    end
  end

  // Outputs; stall covers the issue cycle so the MUL holds in EX.
  always_comb begin
    busy_o   = (state_q == S_BUSY);
    valid_o  = (state_q == S_DONE);
    stall_o  = (state_q == S_BUSY) | accept;
    result_o = res_q;
  end

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// tb_mul_seq_ctrl: directed bench for mul_seq_ctrl with a
// cycle-level reference model and literal end-of-test checks.
module tb_mul_seq_ctrl;

  localparam int W = 32;
  localparam logic [2:0] MUL = 3'b010;
  localparam logic [2:0] ADD = 3'b000;

`ifdef MUL_EARLY_TERM_EN
  localparam int L1  = 4;
  localparam int L4  = 5;
  localparam int L6A = 4;
  localparam int L6B = 8;
`else
  localparam int L1  = 33;
  localparam int L4  = 33;
  localparam int L6A = 33;
  localparam int L6B = 66;
`endif

  logic         clk_i = 0;
  logic         rst_i;
  logic         start_i;
  logic [2:0]   ALUCtrl_i;
  logic         flush_i;
  logic [W-1:0] data1_i;
  logic [W-1:0] data2_i;
  logic         stall_o;
  logic         busy_o;
  logic         valid_o;
  logic [W-1:0] result_o;

  mul_seq_ctrl #(.WIDTH(W), .MUL_CODE(MUL)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i),
    .ALUCtrl_i(ALUCtrl_i), .flush_i(flush_i),
    .data1_i(data1_i), .data2_i(data2_i),
    .stall_o(stall_o), .busy_o(busy_o),
    .valid_o(valid_o), .result_o(result_o)
  );

  always #5 clk_i = ~clk_i;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference model: an outstanding MUL with a count of
  // remaining BUSY cycles; 0 remaining means the result cycle.
  bit           pend = 0;
  int           rem = 0;
  logic [W-1:0] prod = '0;
  logic [W-1:0] last_res = '0;
  bit           acc_e = 0;
  bit           busy_e = 0;
  bit           valid_e = 0;
  int           cyc = 0;
  int           stall_cnt = 0;
  int           vq_cyc[$];
  logic [W-1:0] vq_res[$];

  function automatic int busy_len(input logic [W-1:0] b);
`ifdef MUL_EARLY_TERM_EN
    int m;
    m = 0;
    for (int i = 0; i < W; i++) if (b[i]) m = i;
    return m + 1;
`else
    return W;
`endif
  endfunction

  function automatic logic [W-1:0] mul_lo(input logic [W-1:0] a,
                                          input logic [W-1:0] b);
    logic [63:0] f;
    f = 64'(a) * 64'(b);
    return f[W-1:0];
  endfunction

  // Compare process: every cycle, well before the rising edge.
  always @(negedge clk_i) begin
    #2;
    if (rst_i) begin
      busy_e  = pend && rem > 0;
      valid_e = pend && rem == 0;
      acc_e   = start_i && ALUCtrl_i == MUL && !flush_i && !busy_e;
      chk("busy_o", 64'(busy_o), 64'(busy_e));
      chk("valid_o", 64'(valid_o), 64'(valid_e));
      chk("stall_o", 64'(stall_o), 64'(busy_e || acc_e));
      chk("result_o", 64'(result_o),
          64'(valid_e ? prod : last_res));
      if (stall_o) stall_cnt++;
      if (valid_o) begin
        vq_cyc.push_back(cyc);
        vq_res.push_back(result_o);
      end
    end
  end

  // Model state update at the active edge.
  always @(posedge clk_i) begin
    cyc++;
    if (rst_i) begin
      if (busy_e) begin
        if (flush_i) pend = 0;
        else rem--;
      end else if (valid_e) begin
        pend = 0;
        last_res = prod;
      end
      if (acc_e) begin
        pend = 1;
        rem  = busy_len(data2_i);
        prod = mul_lo(data1_i, data2_i);
      end
    end
  end

  task automatic step(input bit s, input logic [2:0] c,
                      input bit f, input logic [W-1:0] a,
                      input logic [W-1:0] b);
    @(negedge clk_i);
    start_i   = s;
    ALUCtrl_i = c;
    flush_i   = f;
    data1_i   = a;
    data2_i   = b;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, ADD, 0, '0, '0);
  endtask

  task automatic clr();
    stall_cnt = 0;
    vq_cyc.delete();
    vq_res.delete();
  endtask

  int iss;
  int iss2;

  initial begin
    rst_i = 0; start_i = 0; ALUCtrl_i = ADD;
    flush_i = 0; data1_i = '0; data2_i = '0;
    #1;
    chk("rst_stall", 64'(stall_o), 64'd0);
    chk("rst_busy", 64'(busy_o), 64'd0);
    chk("rst_valid", 64'(valid_o), 64'd0);
    chk("rst_result", 64'(result_o), 64'd0);
    repeat (2) @(negedge clk_i);
    rst_i = 1;
    idle(2);

    // 1: 7*6
    clr();
    step(1, MUL, 0, 32'd7, 32'd6);
    iss = cyc;
    idle(40);
    chk("t1_nvalid", 64'(vq_cyc.size()), 64'd1);
    if (vq_cyc.size() > 0) begin
      chk("t1_lat", 64'(vq_cyc[0] - iss), 64'(L1));
      chk("t1_res", 64'(vq_res[0]), 64'd42);
    end
    chk("t1_stall_cycles", 64'(stall_cnt), 64'(L1));

    // 2: wrap cases
    clr();
    step(1, MUL, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    idle(40);
    step(1, MUL, 0, 32'h8000_0000, 32'd2);
    idle(40);
    chk("t2_nvalid", 64'(vq_cyc.size()), 64'd2);
    if (vq_cyc.size() > 1) begin
      chk("t2_res_ff", 64'(vq_res[0]), 64'h1);
      chk("t2_res_wrap", 64'(vq_res[1]), 64'h0);
    end

    // 3: ADD never stalls
    clr();
    step(1, ADD, 0, 32'd3, 32'd4);
    step(1, ADD, 0, 32'd9, 32'd9);
    step(1, 3'b001, 0, 32'd9, 32'd9);
    idle(5);
    chk("t3_stall_cycles", 64'(stall_cnt), 64'd0);
    chk("t3_nvalid", 64'(vq_cyc.size()), 64'd0);

    // 4: flush at c10, new MUL at c12
    clr();
    step(1, MUL, 0, 32'd11, 32'h8000_0001);
    idle(9);
    step(0, ADD, 1, '0, '0);
    idle(1);
    step(1, MUL, 0, 32'd9, 32'd9);
    iss2 = cyc;
    idle(40);
    chk("t4_nvalid", 64'(vq_cyc.size()), 64'd1);
    if (vq_cyc.size() > 0) begin
      chk("t4_lat", 64'(vq_cyc[0] - iss2), 64'(L4));
      chk("t4_res", 64'(vq_res[0]), 64'd81);
    end

    // 5: reset mid-BUSY at c15
    clr();
    step(1, MUL, 0, 32'd13, 32'h8000_0001);
    idle(14);
    @(negedge clk_i);
    start_i = 0;
    #3;
    rst_i = 0;
    pend = 0; last_res = '0;
    acc_e = 0; busy_e = 0; valid_e = 0;
    #1;
    chk("t5_stall", 64'(stall_o), 64'd0);
    chk("t5_busy", 64'(busy_o), 64'd0);
    chk("t5_valid", 64'(valid_o), 64'd0);
    chk("t5_result", 64'(result_o), 64'd0);
    repeat (2) @(negedge clk_i);
    rst_i = 1;
    idle(1);
    clr();
    step(1, MUL, 0, 32'd3, 32'd5);
    idle(40);
    chk("t5_nvalid", 64'(vq_cyc.size()), 64'd1);
    if (vq_cyc.size() > 0) chk("t5_res", 64'(vq_res[0]), 64'd15);

    // 6: back-to-back issue in the DONE cycle
    clr();
    step(1, MUL, 0, 32'd3, 32'd4);
    iss = cyc;
    idle(L6A - 1);
    step(1, MUL, 0, 32'd5, 32'd5);
    idle(40);
    chk("t6_nvalid", 64'(vq_cyc.size()), 64'd2);
    if (vq_cyc.size() > 1) begin
      chk("t6_lat_a", 64'(vq_cyc[0] - iss), 64'(L6A));
      chk("t6_res_a", 64'(vq_res[0]), 64'd12);
      chk("t6_lat_b", 64'(vq_cyc[1] - iss), 64'(L6B));
      chk("t6_res_b", 64'(vq_res[1]), 64'd25);
    end
    chk("t6_stall_cycles", 64'(stall_cnt), 64'(L6B));

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
